// File: rtl/cpu_pkg.sv
// Definitions shared across the 16-bit CPU: ALU operation codes, instruction
// opcodes, instruction field layout and the decoded-control bundle.
package cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD        = 4'd0,
        ALU_SUB        = 4'd1,
        ALU_EVEN_UPPER = 4'd2,
        ALU_EVEN_LOWER = 4'd3,
        ALU_GTE        = 4'd4,
        ALU_LTZ        = 4'd5,
        ALU_EZ         = 4'd6,
        ALU_EQ         = 4'd7,
        ALU_NE         = 4'd8
    } alu_op_e;

    typedef enum logic [3:0] {
        OPC_ADD  = 4'h0,
        OPC_SUB  = 4'h1,
        OPC_PARU = 4'h2,
        OPC_PARL = 4'h3,
        OPC_BGE  = 4'h4,
        OPC_BLTZ = 4'h5,
        OPC_BEZ  = 4'h6,
        OPC_BEQ  = 4'h7,
        OPC_BNE  = 4'h8,
        OPC_LW   = 4'h9,
        OPC_SW   = 4'hA,
        OPC_ADDI = 4'hB
    } opcode_e;

    // Source of the second ALU operand.
    typedef enum logic [1:0] {
        OP1_REG,
        OP1_ZERO,
        OP1_ZIMM,
        OP1_SIMM
    } op1_sel_e;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned FIELD_W = 4;
    localparam int unsigned OPC_LSB = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS_LSB  = 4;
    localparam int unsigned RT_LSB  = 0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        alu_op_e  operation;
        op1_sel_e op1_sel;
        logic     wr_en;
        logic     is_branch;
        logic     is_load;
        logic     is_store;
        logic     uses_rs;
        logic     uses_rt;
        logic     illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic logic [FIELD_W-1:0] field(input logic [INSTR_W-1:0] instr,
                                                 input int unsigned lsb);
        return instr[lsb +: FIELD_W];
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: ALU operation, operand sources, register
// usage and control flags for one instruction.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [FIELD_W-1:0] opc,
    output ctrl_t              ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (opc)
            OPC_ADD: begin
                ctrl.operation = ALU_ADD;
                ctrl.op1_sel   = OP1_REG;
                ctrl.wr_en     = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OPC_SUB: begin
                ctrl.operation = ALU_SUB;
                ctrl.op1_sel   = OP1_REG;
                ctrl.wr_en     = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OPC_PARU: begin
                ctrl.operation = ALU_EVEN_UPPER;
                ctrl.op1_sel   = OP1_ZERO;
                ctrl.wr_en     = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OPC_PARL: begin
                ctrl.operation = ALU_EVEN_LOWER;
                ctrl.op1_sel   = OP1_ZERO;
                ctrl.wr_en     = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OPC_BGE: begin
                ctrl.operation = ALU_GTE;
                ctrl.op1_sel   = OP1_REG;
                ctrl.is_branch = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OPC_BLTZ: begin
                ctrl.operation = ALU_LTZ;
                ctrl.op1_sel   = OP1_ZERO;
                ctrl.is_branch = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OPC_BEZ: begin
                ctrl.operation = ALU_EZ;
                ctrl.op1_sel   = OP1_ZERO;
                ctrl.is_branch = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OPC_BEQ: begin
                ctrl.operation = ALU_EQ;
                ctrl.op1_sel   = OP1_REG;
                ctrl.is_branch = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OPC_BNE: begin
                ctrl.operation = ALU_NE;
                ctrl.op1_sel   = OP1_REG;
                ctrl.is_branch = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OPC_LW: begin
                ctrl.operation = ALU_ADD;
                ctrl.op1_sel   = OP1_ZIMM;
                ctrl.wr_en     = 1'b1;
                ctrl.is_load   = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            OPC_SW: begin
                // Address is rs+0; rt only supplies the store data.
                ctrl.operation = ALU_ADD;
                ctrl.op1_sel   = OP1_ZERO;
                ctrl.is_store  = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OPC_ADDI: begin
                ctrl.operation = ALU_ADD;
                ctrl.op1_sel   = OP1_SIMM;
                ctrl.wr_en     = 1'b1;
                ctrl.uses_rs   = 1'b1;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: fetch handshake, operand read with writeback bypass,
// load-use and flush handling, and the ID/EX pipeline register.
module id_issue_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 16,
    parameter int NREG = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid,
    input  logic [XLEN-1:0]         if_instr,
    input  logic [XLEN-1:0]         if_pc,
    output logic                    if_ready,
    output logic [$clog2(NREG)-1:0] rf_raddr0,
    output logic [$clog2(NREG)-1:0] rf_raddr1,
    input  logic [XLEN-1:0]         rf_rdata0,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic                    wb_we,
    input  logic [$clog2(NREG)-1:0] wb_addr,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    flush,
    input  logic                    ex_ready,
    output logic                    ex_valid,
    output logic [3:0]              ex_operation,
    output logic [XLEN-1:0]         ex_readData0,
    output logic [XLEN-1:0]         ex_readData1,
    output logic [XLEN-1:0]         ex_store_data,
    output logic [$clog2(NREG)-1:0] ex_rd,
    output logic [$clog2(NREG)-1:0] ex_rs,
    output logic [$clog2(NREG)-1:0] ex_rt,
    output logic                    ex_wr_en,
    output logic                    ex_is_branch,
    output logic                    ex_is_load,
    output logic                    ex_is_store,
    output logic [XLEN-1:0]         ex_branch_target,
    output logic                    illegal,
    output logic [15:0]             stall_count
);

    localparam int AW = $clog2(NREG);

    typedef struct packed {
        logic            valid;
        logic [3:0]      operation;
        logic [XLEN-1:0] data0;
        logic [XLEN-1:0] data1;
        logic [XLEN-1:0] store_data;
        logic [AW-1:0]   rd;
        logic [AW-1:0]   rs;
        logic [AW-1:0]   rt;
        logic            wr_en;
        logic            is_branch;
        logic            is_load;
        logic            is_store;
        logic [XLEN-1:0] target;
    } idex_t;

    ctrl_t               dec;
    logic [FIELD_W-1:0]  opc;
    logic [FIELD_W-1:0]  imm;
    logic [FIELD_W-1:0]  off;
    logic [AW-1:0]       rd;
    logic [AW-1:0]       rs;
    logic [AW-1:0]       rt;
    logic [XLEN-1:0]     op_a;
    logic [XLEN-1:0]     op_b;
    logic [XLEN-1:0]     imm_sext;
    logic [XLEN-1:0]     off_sext;
    logic                hold;
    logic                load_use;
    logic                illegal_set;
    logic                stall_inc;
    logic                idex_en;
    idex_t               idex_q;
    idex_t               idex_d;
    idex_t               issue;

    assign opc = field(if_instr, OPC_LSB);
    assign imm = field(if_instr, RT_LSB);
    assign off = field(if_instr, RD_LSB);
    assign rd  = AW'(field(if_instr, RD_LSB));
    assign rs  = AW'(field(if_instr, RS_LSB));
    assign rt  = AW'(field(if_instr, RT_LSB));

    assign imm_sext = {{(XLEN-FIELD_W){imm[FIELD_W-1]}}, imm};
    assign off_sext = {{(XLEN-FIELD_W){off[FIELD_W-1]}}, off};

    instr_decode u_decode (
        .opc  (opc),
        .ctrl (dec)
    );

    assign rf_raddr0 = rs;
    assign rf_raddr1 = rt;

    // r0 is hard zero; a same-cycle writeback overrides the register file.
    assign op_a = (rs == '0) ? '0 : ((wb_we && wb_addr == rs) ? wb_data : rf_rdata0);
    assign op_b = (rt == '0) ? '0 : ((wb_we && wb_addr == rt) ? wb_data : rf_rdata1);

    assign hold     = idex_q.valid & ~ex_ready;
    assign load_use = if_valid & idex_q.valid & idex_q.is_load & (idex_q.rd != '0)
                    & ((dec.uses_rs & (rs == idex_q.rd)) | (dec.uses_rt & (rt == idex_q.rd)));

    assign if_ready    = ~rst & (flush | (~hold & ~load_use));
    assign illegal_set = if_valid & if_ready & ~flush & dec.illegal;

    always_comb begin
        issue            = '0;
        issue.valid      = 1'b1;
        issue.operation  = dec.operation;
        issue.data0      = dec.uses_rs ? op_a : '0;
        case (dec.op1_sel)
            OP1_REG:  issue.data1 = op_b;
            OP1_ZIMM: issue.data1 = {{(XLEN-FIELD_W){1'b0}}, imm};
            OP1_SIMM: issue.data1 = imm_sext;
            default:  issue.data1 = '0;
        endcase
        issue.store_data = dec.is_store ? op_b : '0;
        issue.rd         = dec.wr_en ? rd : '0;
        issue.rs         = dec.uses_rs ? rs : '0;
        issue.rt         = dec.uses_rt ? rt : '0;
        issue.wr_en      = dec.wr_en;
        issue.is_branch  = dec.is_branch;
        issue.is_load    = dec.is_load;
        issue.is_store   = dec.is_store;
        issue.target     = dec.is_branch ? (if_pc + XLEN'(1) + off_sext) : '0;
    end

    // Priority: flush > EX hold > load-use bubble > issue; illegal issues a bubble.
    always_comb begin
        idex_en   = 1'b1;
        idex_d    = '0;
        stall_inc = 1'b0;
        if (flush) begin
            idex_d = '0;
        end else if (hold) begin
            idex_en = 1'b0;
        end else if (load_use) begin
            stall_inc = 1'b1;
        end else if (if_valid && !dec.illegal) begin
            idex_d = issue;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q      <= '0;
            illegal     <= 1'b0;
            stall_count <= '0;
        end else begin
            if (idex_en) begin
                idex_q <= idex_d;
            end
            if (illegal_set) begin
                illegal <= 1'b1;
            end
            if (stall_inc && stall_count != '1) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

    assign ex_valid         = idex_q.valid;
    assign ex_operation     = idex_q.operation;
    assign ex_readData0     = idex_q.data0;
    assign ex_readData1     = idex_q.data1;
    assign ex_store_data    = idex_q.store_data;
    assign ex_rd            = idex_q.rd;
    assign ex_rs            = idex_q.rs;
    assign ex_rt            = idex_q.rt;
    assign ex_wr_en         = idex_q.wr_en;
    assign ex_is_branch     = idex_q.is_branch;
    assign ex_is_load       = idex_q.is_load;
    assign ex_is_store      = idex_q.is_store;
    assign ex_branch_target = idex_q.target;

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage: directed cases then randomized traffic,
// checked against an instruction-level reference model.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready;
    logic [3:0]  rf_raddr0;
    logic [3:0]  rf_raddr1;
    logic [15:0] rf_rdata0;
    logic [15:0] rf_rdata1;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [3:0]  ex_operation;
    logic [15:0] ex_readData0;
    logic [15:0] ex_readData1;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_rd;
    logic [3:0]  ex_rs;
    logic [3:0]  ex_rt;
    logic        ex_wr_en;
    logic        ex_is_branch;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [15:0] ex_branch_target;
    logic        illegal;
    logic [15:0] stall_count;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] sd;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic        wr;
        logic        br;
        logic        ld;
        logic        st;
        logic [15:0] tgt;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] regs [16];
    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state: what the ID/EX register should hold.
    logic        m_valid;
    logic [3:0]  m_load_rd;
    logic [15:0] m_stalls;
    logic        m_illegal;

    always #5 clk = ~clk;

    assign rf_rdata0 = regs[rf_raddr0];
    assign rf_rdata1 = regs[rf_raddr1];

    id_issue_stage #(.XLEN(16), .NREG(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_ready         (if_ready),
        .rf_raddr0        (rf_raddr0),
        .rf_raddr1        (rf_raddr1),
        .rf_rdata0        (rf_rdata0),
        .rf_rdata1        (rf_rdata1),
        .wb_we            (wb_we),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .flush            (flush),
        .ex_ready         (ex_ready),
        .ex_valid         (ex_valid),
        .ex_operation     (ex_operation),
        .ex_readData0     (ex_readData0),
        .ex_readData1     (ex_readData1),
        .ex_store_data    (ex_store_data),
        .ex_rd            (ex_rd),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .ex_wr_en         (ex_wr_en),
        .ex_is_branch     (ex_is_branch),
        .ex_is_load       (ex_is_load),
        .ex_is_store      (ex_is_store),
        .ex_branch_target (ex_branch_target),
        .illegal          (illegal),
        .stall_count      (stall_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] rd_reg(input logic [3:0] a);
        if (a == 4'd0) return 16'd0;
        if (wb_we && wb_addr == a) return wb_data;
        return regs[a];
    endfunction

    function automatic logic reads_rt(input int unsigned opc);
        return opc inside {0, 1, 4, 7, 8, 10};
    endfunction

    function automatic logic reads_reg(input logic [15:0] ins, input logic [3:0] r);
        int unsigned opc;
        opc = ins[15:12];
        if (opc >= 12) return 1'b0;
        return (ins[7:4] == r) || (reads_rt(opc) && ins[3:0] == r);
    endfunction

    function automatic exp_t predict(input logic [15:0] ins, input logic [15:0] pc);
        exp_t        e;
        int unsigned opc;
        logic [3:0]  a, b, c;
        opc = ins[15:12];
        a = ins[11:8];
        b = ins[7:4];
        c = ins[3:0];
        e = '0;
        e.op = (opc <= 8) ? 4'(opc) : 4'd0;
        e.d0 = rd_reg(b);
        e.rs = b;
        if (opc inside {0, 1, 4, 7, 8}) e.d1 = rd_reg(c);
        else if (opc == 9)               e.d1 = {12'd0, c};
        else if (opc == 11)              e.d1 = {{12{c[3]}}, c};
        if (reads_rt(opc)) e.rt = c;
        if (opc == 10) begin
            e.sd = rd_reg(c);
            e.st = 1'b1;
        end
        if (opc inside {0, 1, 2, 3, 9, 11}) begin
            e.wr = 1'b1;
            e.rd = a;
        end
        e.ld = (opc == 9);
        if (opc >= 4 && opc <= 8) begin
            e.br  = 1'b1;
            e.tgt = pc + 16'd1 + {{12{a[3]}}, a};
        end
        return e;
    endfunction

    // Monitor: an entry leaves ID/EX when EX accepts it, or is squashed by flush.
    always @(negedge clk) begin
        exp_t act, e;
        if (!rst && ex_valid) begin
            act = {ex_operation, ex_readData0, ex_readData1, ex_store_data, ex_rd, ex_rs,
                   ex_rt, ex_wr_en, ex_is_branch, ex_is_load, ex_is_store, ex_branch_target};
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ex_unexpected: got live instruction op=%0d, required no entry", act.op);
            end else if (ex_ready) begin
                e = sb.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL ex_bundle: got op=%0d d0=%h d1=%h sd=%h rd=%0d rs=%0d rt=%0d wr=%b br=%b ld=%b st=%b tgt=%h required op=%0d d0=%h d1=%h sd=%h rd=%0d rs=%0d rt=%0d wr=%b br=%b ld=%b st=%b tgt=%h",
                             act.op, act.d0, act.d1, act.sd, act.rd, act.rs, act.rt, act.wr, act.br, act.ld, act.st, act.tgt,
                             e.op, e.d0, e.d1, e.sd, e.rd, e.rs, e.rt, e.wr, e.br, e.ld, e.st, e.tgt);
                end
            end else if (flush) begin
                void'(sb.pop_front());
            end
        end
    end

    // One clock cycle of stimulus; entered and left just after a rising edge.
    task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                        input logic fl, input logic er, input logic we,
                        input logic [3:0] wa, input logic [15:0] wd, output logic acc);
        logic luse, exp_ready;
        chk("ex_valid", ex_valid, m_valid);
        chk("stall_count", stall_count, m_stalls);
        chk("illegal", illegal, m_illegal);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
        flush    = fl;
        ex_ready = er;
        wb_we    = we;
        wb_addr  = wa;
        wb_data  = wd;
        #1;
        luse = v && m_valid && m_load_rd != 4'd0 && reads_reg(ins, m_load_rd);
        exp_ready = fl || ((!m_valid || er) && !luse);
        chk("if_ready", if_ready, exp_ready);
        acc = 1'b0;
        if (fl) begin
            m_valid = 1'b0;
            m_load_rd = 4'd0;
        end else if (m_valid && !er) begin
            // held: nothing changes
        end else if (luse) begin
            m_valid = 1'b0;
            m_load_rd = 4'd0;
            if (m_stalls != 16'hFFFF) m_stalls++;
        end else if (v) begin
            acc = 1'b1;
            if (ins[15:12] >= 4'hC) begin
                m_illegal = 1'b1;
                m_valid = 1'b0;
                m_load_rd = 4'd0;
            end else begin
                m_valid = 1'b1;
                m_load_rd = (ins[15:12] == 4'h9) ? ins[11:8] : 4'd0;
                sb.push_back(predict(ins, pc));
            end
        end else begin
            m_valid = 1'b0;
            m_load_rd = 4'd0;
        end
        @(posedge clk);
        if (we && wa != 4'd0) regs[wa] = wd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_valid = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b0;
        wb_we = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("if_ready_in_rst", if_ready, 1'b0);
        rst = 1'b0;
        sb.delete();
        m_valid = 1'b0;
        m_load_rd = 4'd0;
        m_stalls = 16'd0;
        m_illegal = 1'b0;
        #1;
        chk("rst_ex_valid", ex_valid, 1'b0);
        chk("rst_ex_bus", {ex_operation, ex_rd, ex_rs, ex_rt, ex_wr_en, ex_is_branch, ex_is_load, ex_is_store}, 0);
        chk("rst_ex_data", ex_readData0 | ex_readData1 | ex_store_data | ex_branch_target, 0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_stall_count", stall_count, 0);
        chk("rst_if_ready", if_ready, 1'b1);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] w;
        logic [3:0]  opc;
        opc = ($urandom_range(0, 99) < 3) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
        w = {opc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
        if (opc == 4'h9 || opc == 4'hB) w[3:0] = 4'($urandom_range(0, 15));
        return w;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic        acc;
        logic        pend;
        logic        v, fl;
        logic [15:0] ins, pc;
        int unsigned tries;

        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
        regs[0] = 16'hDEAD;
        if_instr = '0;
        if_pc = '0;
        wb_addr = '0;
        wb_data = '0;
        do_reset();

        // ADD r3,r1,r2 with R1=5, R2=7
        step(0, 16'h0, 16'h0, 0, 1, 1, 4'd1, 16'd5, acc);
        step(0, 16'h0, 16'h0, 0, 1, 1, 4'd2, 16'd7, acc);
        step(1, 16'h0312, 16'h0000, 0, 1, 0, 4'd0, 16'd0, acc);
        chk("add_accepted", acc, 1'b1);

        // LW r4 then ADD r5,r4,r4: one bubble
        step(1, 16'h9412, 16'h0001, 0, 1, 0, 4'd0, 16'd0, acc);
        tries = 0;
        do begin
            step(1, 16'h0544, 16'h0002, 0, 1, 0, 4'd0, 16'd0, acc);
            tries++;
        end while (!acc && tries < 5);
        chk("load_use_retries", tries, 2);
        chk("load_use_stalls", m_stalls, 1);

        // BEQ off=-2 at 0x0010, then flush drops the next offered instruction
        step(1, 16'h7E12, 16'h0010, 0, 1, 0, 4'd0, 16'd0, acc);
        step(1, 16'h0111, 16'h0011, 1, 1, 0, 4'd0, 16'd0, acc);
        chk("flush_dropped", acc, 1'b0);

        // Writeback bypass on rs, r0 on rt
        step(1, 16'h1210, 16'h0020, 0, 1, 1, 4'd1, 16'hABCD, acc);

        // Branch target wraps past 0xFFFF
        step(1, 16'h6010, 16'hFFFF, 0, 1, 0, 4'd0, 16'd0, acc);

        // EX hold for three cycles
        step(1, 16'h0312, 16'h0030, 0, 1, 0, 4'd0, 16'd0, acc);
        for (int i = 0; i < 3; i++) step(1, 16'h0123, 16'h0031, 0, 0, 0, 4'd0, 16'd0, acc);
        step(1, 16'h0123, 16'h0031, 0, 1, 0, 4'd0, 16'd0, acc);
        chk("hold_release_accept", acc, 1'b1);

        // Illegal opcode
        step(1, 16'hC000, 16'h0040, 0, 1, 0, 4'd0, 16'd0, acc);
        step(0, 16'h0000, 16'h0041, 0, 1, 0, 4'd0, 16'd0, acc);
        step(0, 16'h0000, 16'h0042, 0, 1, 0, 4'd0, 16'd0, acc);

        // Reset while held behind a load
        step(1, 16'h9112, 16'h0050, 0, 1, 0, 4'd0, 16'd0, acc);
        step(1, 16'h0211, 16'h0051, 0, 0, 0, 4'd0, 16'd0, acc);
        do_reset();

        // Randomized traffic; fetch keeps an unaccepted instruction stable
        pend = 1'b0;
        ins = '0;
        pc = '0;
        for (int n = 0; n < 1500; n++) begin
            if (!pend) begin
                ins = rand_instr();
                pc = 16'($urandom);
            end
            v = pend ? 1'b1 : ($urandom_range(0, 9) < 8);
            fl = ($urandom_range(0, 99) < 8);
            step(v, ins, pc, fl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 3),
                 4'($urandom_range(0, 3)), 16'($urandom), acc);
            pend = v && !acc && !fl;
        end

        for (int i = 0; i < 3; i++) step(0, 16'h0, 16'h0, 0, 1, 0, 4'd0, 16'd0, acc);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
